// File: rtl/vlc_pkg.sv
// -----------------------------------------------------------------------------
// vlc_pkg
// Shared definitions for the VLC stream packer:
//   - default widths (code, output word, block length)
//   - FSM state encoding
//   - lenmask(): low-order ones mask used to strip bits above a code length
// -----------------------------------------------------------------------------
package vlc_pkg;

  localparam int VLC_CODE_W  = 8;
  localparam int VLC_OUT_W   = 32;
  localparam int VLC_BLK_LEN = 64;

  // lenmask() is built wide enough for any legal CODE_W (CODE_W <= OUT_W <= 64).
  // Callers size-cast the result down to their own code width.
  localparam int VLC_MASK_W  = 64;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } vlc_state_e;

  // Returns a mask with the lowest `len` bits set.
  function automatic logic [VLC_MASK_W-1:0] lenmask(input int unsigned len);
    logic [VLC_MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < VLC_MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/vlc_bit_accum.sv
// -----------------------------------------------------------------------------
// vlc_bit_accum
// Bit accumulator for the VLC stream packer. Holds a 2*OUT_W-bit shift
// register and its fill level. Codes are OR-ed in at bit offset `fill`
// (LSB-first); a pop drops the lowest OUT_W bits. Insert and pop may happen
// in the same cycle: the pop is applied first, then the insert lands at the
// reduced fill. clr empties the accumulator (used after the final word).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ins_en_i      insert ins_code_i / ins_len_i this cycle
//   ins_code_i    code bits, already masked to ins_len_i
//   ins_len_i     code length in bits
//   pop_en_i      discard the lowest OUT_W bits this cycle
//   clr_i         empty the accumulator (overrides insert/pop)
//   fill_d_o      next-state fill level
//   word_d_o      next-state lowest OUT_W bits of the accumulator
// -----------------------------------------------------------------------------
module vlc_bit_accum #(
  parameter int CODE_W = 8,
  parameter int OUT_W  = 32,
  parameter int FW     = $clog2(2*OUT_W+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_en_i,
  input  logic [CODE_W-1:0] ins_code_i,
  input  logic [FW-1:0]     ins_len_i,
  input  logic              pop_en_i,
  input  logic              clr_i,
  output logic [FW-1:0]     fill_d_o,
  output logic [OUT_W-1:0]  word_d_o
);

  localparam int ACC_W = 2*OUT_W;

  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic [FW-1:0]    fill_q, fill_d, fill_base;

  always_comb begin
    acc_base  = acc_q;
    fill_base = fill_q;
    if (pop_en_i) begin
      acc_base  = acc_q >> OUT_W;
      fill_base = fill_q - FW'(OUT_W);
    end

    acc_d  = acc_base;
    fill_d = fill_base;
    // Bits above fill are always zero, so OR-in is a plain insert.
    if (ins_en_i) begin
      acc_d  = acc_base | (ACC_W'(ins_code_i) << fill_base);
      fill_d = fill_base + ins_len_i;
    end

    if (clr_i) begin
      acc_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign fill_d_o = fill_d;
  assign word_d_o = acc_d[OUT_W-1:0];

endmodule

// File: rtl/vlc_stream_packer.sv
// -----------------------------------------------------------------------------
// vlc_stream_packer
// Packs one variable-length code per cycle (valid/ready) LSB-first into
// OUT_W-bit words (valid/ready). A block ends on an accepted in_last or on
// the BLK_LEN-th symbol; its final partial word is padded and flagged with
// out_last, out_bits gives the valid bits in that word and blk_bits the total
// bits of the block.
//
// Build option:
//   VLC_PAD_ONES_EN  defined   -> padding bits of the final word are 1
//                    undefined -> padding bits are 0
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    code present             in_ready   packer accepts code
//   in_code     code bits, LSB-aligned   in_len     code length 0..CODE_W
//   in_last     final symbol of block
//   out_valid   word present             out_ready  downstream accepts word
//   out_data    packed word              out_last   final word of block
//   out_bits    valid bits in out_data   blk_bits   total bits in block
//   len_err     sticky: an in_len > CODE_W was accepted
//
// All outputs are registers. Their next values are decoded from the
// accumulator's next state, so out_* hold steady while stalled and appear one
// cycle after the accepting edge.
// -----------------------------------------------------------------------------
module vlc_stream_packer
  import vlc_pkg::*;
#(
  parameter int CODE_W  = VLC_CODE_W,
  parameter int LEN_W   = 4,
  parameter int OUT_W   = VLC_OUT_W,
  parameter int BLK_LEN = VLC_BLK_LEN,
  parameter int CNT_W   = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CODE_W-1:0]          in_code,
  input  logic [LEN_W-1:0]           in_len,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_last,
  output logic [$clog2(OUT_W+1)-1:0] out_bits,
  output logic [CNT_W-1:0]           blk_bits,
  output logic                       len_err
);

  localparam int FW  = $clog2(2*OUT_W+1);
  localparam int OBW = $clog2(OUT_W+1);
  localparam int SW  = $clog2(BLK_LEN+1);

  vlc_state_e       state_q, state_d;
  logic [SW-1:0]    sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] blk_bits_q, blk_bits_d;
  logic             len_err_q, len_err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [OBW-1:0]   out_bits_q, out_bits_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic              accept, pop, final_hs, len_over;
  logic [LEN_W-1:0]  len_eff;
  logic [CODE_W-1:0] code_m;
  logic [FW-1:0]     fill_d;
  logic [OUT_W-1:0]  word_d;
  logic [OUT_W-1:0]  pad_bits;
  logic              final_d;

  assign accept   = in_valid & in_ready_q;
  assign pop      = out_valid_q & out_ready & ~out_last_q;
  assign final_hs = out_valid_q & out_ready & out_last_q;

  // Oversized lengths are clamped to CODE_W and flagged.
  assign len_over = in_len > LEN_W'(CODE_W);
  assign len_eff  = len_over ? LEN_W'(CODE_W) : in_len;
  assign code_m   = in_code & CODE_W'(lenmask(32'(len_eff)));

  vlc_bit_accum #(
    .CODE_W (CODE_W),
    .OUT_W  (OUT_W),
    .FW     (FW)
  ) u_accum (
    .clk        (clk),
    .rst        (rst),
    .ins_en_i   (accept),
    .ins_code_i (code_m),
    .ins_len_i  (FW'(len_eff)),
    .pop_en_i   (pop),
    .clr_i      (final_hs),
    .fill_d_o   (fill_d),
    .word_d_o   (word_d)
  );

  // ---------------------------------------------------------------------------
  // FSM and block counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    blk_bits_d = blk_bits_q;
    len_err_d  = len_err_q | (accept & len_over);

    case (state_q)
      ACCUM: begin
        if (accept && (in_last || (sym_cnt_q == SW'(BLK_LEN-1)))) state_d = FLUSH;
      end
      FLUSH: begin
        if (final_hs) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase

    // len=0 symbols still count toward BLK_LEN.
    if (accept) begin
      sym_cnt_d  = sym_cnt_q + SW'(1);
      blk_bits_d = blk_bits_q + CNT_W'(len_eff);
    end
    if (final_hs) begin
      sym_cnt_d  = '0;
      blk_bits_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      sym_cnt_q  <= '0;
      blk_bits_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      blk_bits_q <= blk_bits_d;
      len_err_q  <= len_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from next state
  // ---------------------------------------------------------------------------
  // In FLUSH a fill of exactly OUT_W is a full word that also closes the block,
  // so it carries out_last. A fill of 0 in FLUSH yields the empty pad word.
  // A trailing len=0 last symbol after a word that already left without
  // out_last also ends up here as an empty pad word, since that word cannot be
  // recalled.
  assign final_d = (state_d == FLUSH) && (fill_d <= FW'(OUT_W));

`ifdef VLC_PAD_ONES_EN
  logic [OUT_W-1:0] pad_mask;
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_pad
      assign pad_mask[gi] = (fill_d <= FW'(gi));
    end
  endgenerate
  assign pad_bits = final_d ? pad_mask : '0;
`else
  // Bits above fill are already zero in the accumulator.
  assign pad_bits = '0;
`endif

  always_comb begin
    out_valid_d = (state_d == FLUSH) || (fill_d >= FW'(OUT_W));
    out_last_d  = final_d;
    out_bits_d  = '0;
    out_data_d  = '0;
    if (out_valid_d) begin
      out_bits_d = (fill_d >= FW'(OUT_W)) ? OBW'(OUT_W) : OBW'(fill_d);
      out_data_d = word_d | pad_bits;
    end
    in_ready_d  = (state_d == ACCUM) && (fill_d < FW'(OUT_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bits_q  <= '0;
      out_data_q  <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_bits_q  <= out_bits_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_bits  = out_bits_q;
  assign out_data  = out_data_q;
  assign blk_bits  = blk_bits_q;
  assign len_err   = len_err_q;

endmodule
